seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seqdet_pkg.sv | 18 +
 rtl/seqdet_shifter.sv | 57 +++++
 rtl/seq_detector_param.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and constants for the parameterised serial sequence detector.
package seqdet_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } seqdet_state_e;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_1011;
  localparam int DEF_RST_LEN = 4;

  // A pattern shorter than two bits is rejected by the config load path.
  localparam int LEN_MIN       = 2;
  localparam int LEN_MAX_LIMIT = 32;

endpackage

// File: rtl/seqdet_shifter.sv
// Bit-history shift register plus fill counter for the sequence detector.
// Fill counts bits consumed since the last clear and saturates at MAX_LEN.
module seqdet_shifter
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int FILL_W  = $clog2(DEF_MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shiftEn_i,
  input  logic               clear_i,
  input  logic               fillClr_i,
  input  logic               bitIn_i,
  output logic [MAX_LEN-1:0] shiftReg_o,
  output logic [MAX_LEN-1:0] shiftNext_o,
  output logic [FILL_W-1:0]  fill_o
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  assign shiftNext_o = {shift_q[MAX_LEN-2:0], bitIn_i};
  assign shiftReg_o  = shift_q;
  assign fill_o      = fill_q;

  // Next history/fill: a clear wins over a shift, a fill clear still keeps the new bit.
  always_comb begin
    shift_d = shift_q;
    fill_d  = fill_q;
    if (clear_i) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (shiftEn_i) begin
      shift_d = shiftNext_o;
      if (fillClr_i) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial sequence detector with run-time loadable pattern and
// selectable overlapping / non-overlapping detection.
// Optional feature: define SEQDET_MATCH_CNT_EN to add the saturating match_cnt port.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int                    MAX_LEN     = DEF_MAX_LEN,
  parameter int                    CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0]    RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                    RST_LEN     = DEF_RST_LEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid,
  input  logic                           bit_in,
  input  logic                           overlap_en,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  output logic                           bit_out,
  output logic [MAX_LEN-1:0]             shift_reg
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]               match_cnt
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LO = LEN_W'(LEN_MIN);
  localparam logic [LEN_W-1:0] LEN_HI = LEN_W'(MAX_LEN);

  seqdet_state_e       state_q, state_d;
  logic                bitOut_q, bitOut_d;
  logic [MAX_LEN-1:0]  pattern_q, pattern_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [MAX_LEN-1:0]  shiftNext;
  logic [MAX_LEN-1:0]  cmpMask;
  logic [LEN_W-1:0]    fill;
  logic                legalLoad;
  logic                consume;
  logic                reachLen;
  logic                patternHit;
  logic                matchHit;

  function automatic logic [MAX_LEN-1:0] lenMask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // A legal load takes the cycle over, so the same-cycle data bit is dropped.
  assign legalLoad  = cfg_load && (cfg_len >= LEN_LO) && (cfg_len <= LEN_HI);
  assign consume    = valid && !legalLoad;
  assign cmpMask    = lenMask(len_q);
  assign reachLen   = ({1'b0, fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q};
  assign patternHit = ((shiftNext ^ pattern_q) & cmpMask) == '0;
  assign matchHit   = consume && patternHit && ((state_q == ARMED) || reachLen);

  seqdet_shifter #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .shiftEn_i   (consume),
    .clear_i     (legalLoad),
    .fillClr_i   (matchHit && !overlap_en),
    .bitIn_i     (bit_in),
    .shiftReg_o  (shift_reg),
    .shiftNext_o (shiftNext),
    .fill_o      (fill)
  );

  // Pattern/length capture; pattern bits above the new length are stored as zero.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    if (legalLoad) begin
      pattern_d = cfg_pattern & lenMask(cfg_len);
      len_d     = cfg_len;
    end
  end

  // Pattern/length registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
    end
  end

  // FSM state register, also holding the registered match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      bitOut_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitOut_q <= bitOut_d;
    end
  end

  // FSM next state: ARMED once enough history exists, back to FILL when history restarts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (consume && reachLen && !(matchHit && !overlap_en)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (matchHit && !overlap_en) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (legalLoad) begin
      state_d = FILL;
    end
  end

  // FSM output: pulse next cycle exactly when a consumed bit completes the pattern.
  always_comb begin
    bitOut_d = matchHit;
  end

  assign bit_out = bitOut_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;

  // Match counter: counts alongside each pulse, sticks at all-ones, cleared by a legal load.
  always_comb begin
    matchCnt_d = matchCnt_q;
    if (legalLoad) begin
      matchCnt_d = '0;
    end else if (matchHit && (matchCnt_q != {CNT_W{1'b1}})) begin
      matchCnt_d = matchCnt_q + CNT_W'(1);
    end
  end

  // Match counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matchCnt_q <= '0;
    end else begin
      matchCnt_q <= matchCnt_d;
    end
  end

  assign match_cnt = matchCnt_q;
`endif

endmodule
